note_lane_sequencer: RTL and testbench
======================================

NOTE_LANE_SEQUENCER -- requirements
Module: note_lane_sequencer

Interface
REQ-001 Parameter LIM_BASE, default 836000: beat-period unit in clocks; lim = LIM_BASE*(4+speed_sel).
REQ-002 Parameter CHART_DEPTH, default 64: number of chart entries per song; CHART_AW = clog2(CHART_DEPTH).
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  one-cycle request to begin or restart a song.
REQ-006 abort  in  1  return to idle and clear the lane.
REQ-007 pause  in  1  level; freeze timing and lane while high.
REQ-008 speed_sel  in  2  tempo select, sampled on accepted start.
REQ-009 chart_note  in  1  note-present bit at chart_addr; combinational ROM, same-cycle data.
REQ-010 chart_addr  out  CHART_AW  current chart index.
REQ-011 padded_notes  out  39  lane register: notes enter at bit 0 and advance toward bit 38; bit 37 is the hit line.
REQ-012 counter  out  23  beat-phase counter, 0..lim-1.
REQ-013 lim  out  23  current beat period.
REQ-014 beat  out  1  one-cycle pulse on the lane-shift cycle.
REQ-015 playing  out  1  high in PLAY or DRAIN.
REQ-016 song_done  out  1  high in DONE.

Function
REQ-017 FSM states: IDLE, PLAY, DRAIN, DONE.
REQ-018 IDLE->PLAY on start: chart_addr=0, counter=0, padded_notes=0, lim latched from speed_sel.
REQ-019 In PLAY/DRAIN with pause low, counter increments by 1 each cycle; at counter==lim-1 it wraps to 0 and beat=1 in that cycle.
REQ-020 On beat in PLAY: padded_notes <= {padded_notes[37:0], chart_note}; chart_addr increments.
REQ-021 PLAY->DRAIN on the beat that consumes entry CHART_DEPTH-1; chart_addr holds at CHART_DEPTH-1.
REQ-022 On beat in DRAIN: shift 0 into bit 0; after the 39th DRAIN beat the lane is empty -> DONE.
REQ-023 In DONE: counter=0, beat=0, lane=0; start -> PLAY as in REQ-018.
REQ-024 pause high: counter, lane, chart_addr and state hold; beat=0; pause overrides a wrap in the same cycle.
REQ-025 start in PLAY or DRAIN is ignored; speed_sel changes mid-song have no effect on lim.
REQ-026 abort in any state -> IDLE next cycle, clearing counter, lane and chart_addr; abort takes priority over start and pause.
REQ-027 lim is constant for a song; the maximum lim (7*LIM_BASE = 5852000) fits in 23 bits.
REQ-028 All outputs are registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-029 rst high: state=IDLE, counter=0, lim=4*LIM_BASE, padded_notes=0, chart_addr=0, beat=0, playing=0, song_done=0.
REQ-030 rst takes priority over all inputs, including mid-song and during pause.

Structure
REQ-031 Shared package gv_pkg holds: the state enum, LANE_W=39, HIT_BIT=37, and the speed_sel encodings.
REQ-032 The counter/wrap/beat logic is one sub-module, beat_timer, with inputs en, clr and lim, and outputs counter and beat.

Verification (bench sets LIM_BASE=4, CHART_DEPTH=8)
REQ-033 Reset, then idle 10 cycles -> all outputs 0; lim=16.
REQ-034 start with speed_sel=2, chart all 1s -> lim=24; first beat when counter 23->0; padded_notes=0x1 after beat 1 and 0xFF after beat 8; state DRAIN.
REQ-035 Chart 10110001, speed 0 -> after 8 beats padded_notes[7:0]=8'b10110001; after 39 DRAIN beats song_done=1 and padded_notes=0.
REQ-036 pause high for 5 cycles at counter=15 -> counter holds at 15 with no beat; wrap occurs 1 cycle after pause falls.
REQ-037 abort together with start at counter=7 in PLAY -> next cycle IDLE, counter=0, lane=0; a later start restarts at chart_addr=0.
REQ-038 rst asserted mid-DRAIN -> next cycle every output equals its REQ-029 value.

Source files
------------

// File: rtl/gv_pkg.sv
// Shared types and constants for the note lane sequencer.
package gv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned LANE_W  = 39;
  localparam int unsigned HIT_BIT = 37;
  localparam int unsigned CNT_W   = 23;
  localparam int unsigned DRAIN_W = $clog2(LANE_W + 1);

  // Tempo select encodings: beat period is LIM_BASE times 4..7
  localparam logic [1:0] SPD_X4 = 2'd0;
  localparam logic [1:0] SPD_X5 = 2'd1;
  localparam logic [1:0] SPD_X6 = 2'd2;
  localparam logic [1:0] SPD_X7 = 2'd3;

endpackage

// File: rtl/beat_timer.sv
// Beat-phase counter: counts 0..lim-1 while enabled and pulses beat on the wrap.
module beat_timer
  import gv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] counter,
  output logic             beat
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      counter <= '0;
      beat    <= 1'b0;
    end else if (en) begin
      if (counter == lim - CNT_W'(1)) begin
        counter <= '0;
        beat    <= 1'b1;
      end else begin
        counter <= counter + CNT_W'(1);
        beat    <= 1'b0;
      end
    end else begin
      beat <= 1'b0;
    end
  end

endmodule

// File: rtl/note_lane_sequencer.sv
// Steps a note chart into a scrolling lane register once per beat, then drains
// the lane empty before reporting the song as done.
module note_lane_sequencer
  import gv_pkg::*;
#(
  parameter  int unsigned LIM_BASE    = 836000,
  parameter  int unsigned CHART_DEPTH = 64,
  localparam int unsigned CHART_AW    = $clog2(CHART_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                pause,
  input  logic [1:0]          speed_sel,
  input  logic                chart_note,
  output logic [CHART_AW-1:0] chart_addr,
  output logic [LANE_W-1:0]   padded_notes,
  output logic [CNT_W-1:0]    counter,
  output logic [CNT_W-1:0]    lim,
  output logic                beat,
  output logic                playing,
  output logic                song_done
);

  function automatic logic [CNT_W-1:0] lim_for(input logic [1:0] spd);
    int unsigned mult;
    case (spd)
      SPD_X5:  mult = 5;
      SPD_X6:  mult = 6;
      SPD_X7:  mult = 7;
      default: mult = 4;
    endcase
    return CNT_W'(LIM_BASE * mult);
  endfunction

  state_t             state, next_state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               start_ok_c, tmr_en_c, tmr_clr_c, wrap_c;
  logic               drain_done_c, last_entry_c, shift_in_c;

  assign drain_done_c = (drain_cnt == DRAIN_W'(LANE_W));
  assign last_entry_c = (chart_addr == CHART_AW'(CHART_DEPTH - 1));
  assign start_ok_c   = start && !abort && !pause &&
                        ((state == ST_IDLE) || (state == ST_DONE));
  // Timer stops once the last drain beat has been issued so no 40th shift occurs
  assign tmr_en_c     = !abort && !pause &&
                        ((state == ST_PLAY) || ((state == ST_DRAIN) && !drain_done_c));
  assign wrap_c       = tmr_en_c && (counter == lim - CNT_W'(1));
  assign shift_in_c   = (state == ST_PLAY) ? chart_note : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tmr_clr_c  = 1'b0;
    if (abort) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: if (start_ok_c) next_state = ST_PLAY;
        ST_PLAY:          if (wrap_c && last_entry_c) next_state = ST_DRAIN;
        ST_DRAIN:         if (drain_done_c && !pause) next_state = ST_DONE;
        default:          next_state = ST_IDLE;
      endcase
    end
    tmr_clr_c = start_ok_c || (next_state == ST_IDLE) || (next_state == ST_DONE);
  end

  // Lane, chart pointer, drain count and tempo latch
  always_ff @(posedge clk) begin
    if (rst) begin
      chart_addr   <= '0;
      padded_notes <= '0;
      drain_cnt    <= '0;
      lim          <= lim_for(SPD_X4);
      playing      <= 1'b0;
      song_done    <= 1'b0;
    end else begin
      playing   <= (next_state == ST_PLAY) || (next_state == ST_DRAIN);
      song_done <= (next_state == ST_DONE);
      if (abort) begin
        chart_addr   <= '0;
        padded_notes <= '0;
        drain_cnt    <= '0;
      end else if (start_ok_c) begin
        chart_addr   <= '0;
        padded_notes <= '0;
        drain_cnt    <= '0;
        lim          <= lim_for(speed_sel);
      end else if (wrap_c) begin
        padded_notes <= {padded_notes[HIT_BIT:0], shift_in_c};
        if ((state == ST_PLAY) && !last_entry_c) chart_addr <= chart_addr + CHART_AW'(1);
        if (state == ST_DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
      end
    end
  end

  beat_timer u_beat_timer (
    .clk     (clk),
    .rst     (rst),
    .en      (tmr_en_c),
    .clr     (tmr_clr_c),
    .lim     (lim),
    .counter (counter),
    .beat    (beat)
  );

endmodule

// File: tb/tb_note_lane_sequencer.sv
// Directed bench for note_lane_sequencer with LIM_BASE=4 and an 8-entry chart.
module tb_note_lane_sequencer;

  localparam int unsigned LB    = 4;
  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  speed_sel = 2'd0;
  logic        chart_note;
  logic [2:0]  chart_addr;
  logic [38:0] padded_notes;
  logic [22:0] counter;
  logic [22:0] lim;
  logic        beat;
  logic        playing;
  logic        song_done;

  logic [7:0]  chart_bits = 8'hFF;
  logic [38:0] exp_lane;
  int          checks = 0;
  int          errors = 0;

  // Entry 0 is the chart's leftmost bit so it lands at lane bit 7 after 8 beats
  assign chart_note = chart_bits[3'd7 - chart_addr];

  always #5 clk = ~clk;

  note_lane_sequencer #(.LIM_BASE(LB), .CHART_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pause        (pause),
    .speed_sel    (speed_sel),
    .chart_note   (chart_note),
    .chart_addr   (chart_addr),
    .padded_notes (padded_notes),
    .counter      (counter),
    .lim          (lim),
    .beat         (beat),
    .playing      (playing),
    .song_done    (song_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input string tag);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 4000) begin
      tick();
      cyc++;
      if (beat) seen++;
    end
    chk(tag, 64'(seen), 64'(n));
  endtask

  task automatic pulse_start(input logic [1:0] spd);
    speed_sel = spd;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    // Reset and idle
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("idle_counter", 64'(counter), 0);
    chk("idle_lane", 64'(padded_notes), 0);
    chk("idle_addr", 64'(chart_addr), 0);
    chk("idle_beat", 64'(beat), 0);
    chk("idle_playing", 64'(playing), 0);
    chk("idle_done", 64'(song_done), 0);
    chk("idle_lim", 64'(lim), 16);

    // All-ones chart at speed 2
    chart_bits = 8'hFF;
    pulse_start(2'd2);
    speed_sel = 2'd0;
    chk("s1_lim", 64'(lim), 24);
    chk("s1_counter0", 64'(counter), 0);
    chk("s1_playing", 64'(playing), 1);
    repeat (23) tick();
    chk("s1_pre_wrap_cnt", 64'(counter), 23);
    chk("s1_pre_wrap_beat", 64'(beat), 0);
    tick();
    chk("s1_wrap_cnt", 64'(counter), 0);
    chk("s1_beat1", 64'(beat), 1);
    chk("s1_lane1", 64'(padded_notes), 1);
    chk("s1_addr1", 64'(chart_addr), 1);
    tick();
    chk("s1_beat_pulse", 64'(beat), 0);
    wait_beats(7, "s1_to_beat8");
    chk("s1_lane8", 64'(padded_notes), 64'hFF);
    chk("s1_addr_hold", 64'(chart_addr), 7);
    chk("s1_lim_kept", 64'(lim), 24);
    wait_beats(1, "s1_drain1");
    chk("s1_drain_lane", 64'(padded_notes), 64'h1FE);
    chk("s1_drain_addr", 64'(chart_addr), 7);
    chk("s1_drain_playing", 64'(playing), 1);

    // Reset in the middle of the drain phase
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_counter", 64'(counter), 0);
    chk("rst_lim", 64'(lim), 16);
    chk("rst_lane", 64'(padded_notes), 0);
    chk("rst_addr", 64'(chart_addr), 0);
    chk("rst_beat", 64'(beat), 0);
    chk("rst_playing", 64'(playing), 0);
    chk("rst_done", 64'(song_done), 0);

    // Patterned chart at speed 0, through drain to done
    chart_bits = 8'b1011_0001;
    pulse_start(2'd0);
    chk("s2_lim", 64'(lim), 16);
    wait_beats(8, "s2_play8");
    chk("s2_lane_low", 64'(padded_notes[7:0]), 64'hB1);
    chk("s2_lane_full", 64'(padded_notes), 64'hB1);
    wait_beats(38, "s2_drain38");
    exp_lane = '0;
    exp_lane[38] = 1'b1;
    chk("s2_lane_edge", 64'(padded_notes), 64'(exp_lane));
    wait_beats(1, "s2_drain39");
    chk("s2_lane_empty", 64'(padded_notes), 0);
    chk("s2_not_done_yet", 64'(song_done), 0);
    tick();
    chk("s2_done", 64'(song_done), 1);
    chk("s2_done_playing", 64'(playing), 0);
    chk("s2_done_beat", 64'(beat), 0);
    repeat (20) tick();
    chk("s2_done_counter", 64'(counter), 0);
    chk("s2_done_hold", 64'(song_done), 1);

    // Pause at the last phase of a beat
    pulse_start(2'd0);
    chk("p_counter0", 64'(counter), 0);
    repeat (15) tick();
    chk("p_counter15", 64'(counter), 15);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("p_hold_cnt", 64'(counter), 15);
      chk("p_hold_beat", 64'(beat), 0);
    end
    chk("p_hold_lane", 64'(padded_notes), 0);
    pause = 1'b0;
    tick();
    chk("p_wrap_cnt", 64'(counter), 0);
    chk("p_wrap_beat", 64'(beat), 1);
    chk("p_wrap_lane", 64'(padded_notes), 1);
    chk("p_wrap_addr", 64'(chart_addr), 1);

    // Abort beats a simultaneous start
    repeat (7) tick();
    chk("a_counter7", 64'(counter), 7);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("a_counter", 64'(counter), 0);
    chk("a_lane", 64'(padded_notes), 0);
    chk("a_addr", 64'(chart_addr), 0);
    chk("a_playing", 64'(playing), 0);
    repeat (3) tick();
    chk("a_idle_counter", 64'(counter), 0);
    pulse_start(2'd1);
    chk("a_restart_lim", 64'(lim), 20);
    chk("a_restart_addr", 64'(chart_addr), 0);
    chk("a_restart_playing", 64'(playing), 1);
    wait_beats(1, "a_restart_beat");
    chk("a_restart_addr1", 64'(chart_addr), 1);
    chk("a_restart_lane", 64'(padded_notes), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
